// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time instruction loader. Packs a byte stream into 32-bit
//               big-endian words and writes them to instruction memory from
//               address 0. A trailing XOR checksum byte is verified before the
//               processor is released from reset.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_check = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_error = 3'd4;

    // Largest legal load: the full memory depth.
    localparam logic [ADDR_WIDTH:0] c_max_words = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Width of the partial word held while the first three bytes arrive.
    localparam int c_asm_width = WORD_WIDTH - 8;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [ADDR_WIDTH:0]    r_word_cnt;
    logic [ADDR_WIDTH:0]    r_load_cnt;
    logic [1:0]             r_byte_cnt;
    logic [c_asm_width-1:0] r_asm;
    logic [7:0]             r_xor;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic                w_start_take;
    logic                w_oversize;
    logic                w_zero_len;
    logic                w_in_load;
    logic                w_in_check;
    logic                w_word_write;
    logic                w_last_word;
    logic                w_sum_ok;
    logic [ADDR_WIDTH:0] w_word_cnt_next;

    assign w_accept        = byte_valid & byte_ready;
    assign w_start_take    = start & ((r_state == c_st_idle) |
                                      (r_state == c_st_done) |
                                      (r_state == c_st_error));
    assign w_oversize      = (load_count > c_max_words);
    assign w_zero_len      = (load_count == '0);
    assign w_in_load       = (r_state == c_st_load);
    assign w_in_check      = (r_state == c_st_check);
    // Fourth byte of a word accepted in LOAD completes that word.
    assign w_word_write    = w_in_load & w_accept & (r_byte_cnt == 2'd3);
    assign w_word_cnt_next = r_word_cnt + 1'b1;
    assign w_last_word     = (w_word_cnt_next == r_load_cnt);
    assign w_sum_ok        = (byte_in == r_xor);

    // Sequencing state plus the status outputs that follow it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            byte_ready <= 1'b0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done, c_st_error: begin
                    if (start) begin
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        if (w_oversize) begin
                            r_state    <= c_st_error;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if (w_zero_len) begin
                            r_state    <= c_st_check;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end else begin
                            r_state    <= c_st_load;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                c_st_load: begin
                    // Stay ready straight into CHECK so the checksum needs no bubble.
                    if (w_word_write && w_last_word) begin
                        r_state <= c_st_check;
                    end
                end
                c_st_check: begin
                    if (w_accept) begin
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        if (w_sum_ok) begin
                            r_state   <= c_st_done;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            r_state <= c_st_error;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    byte_ready <= 1'b0;
                    cpu_reset  <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

    // Byte/word counters, big-endian word assembly and running checksum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_load_cnt <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_xor      <= '0;
        end else if (w_start_take) begin
            r_word_cnt <= '0;
            r_load_cnt <= load_count;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_xor      <= '0;
        end else if (w_in_load && w_accept) begin
            r_xor <= r_xor ^ byte_in;
            // Shifting keeps the oldest byte in the top lane; after a full
            // word the next three bytes push the stale ones out.
            r_asm <= {r_asm[c_asm_width-9:0], byte_in};
            if (r_byte_cnt == 2'd3) begin
                r_byte_cnt <= '0;
                r_word_cnt <= w_word_cnt_next;
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // One-cycle memory write strobe with the completed word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_we   <= 1'b0;
            imem_data <= '0;
        end else begin
            imem_we <= w_word_write;
            if (w_word_write) begin
                imem_data <= {r_asm, byte_in};
            end
        end
    end

    // Write address advances once the strobe has been presented; a new load
    // rewinds to 0. Wrapping after the last word of a full load is benign.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_addr <= '0;
        end else if (w_start_take) begin
            imem_addr <= '0;
        end else if (imem_we) begin
            imem_addr <= imem_addr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. A transaction-level
//               model (byte queue, word index arithmetic) predicts every
//               output each cycle; literal expectations pin the key results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_DONE  = 3;
    localparam int PH_ERR   = 4;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [AW:0]   load_count = '0;
    logic [7:0]    byte_in    = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_count (load_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    int            m_phase   = PH_IDLE;
    int            m_need    = 0;
    int            m_written = 0;
    logic [7:0]    m_bytes[$];
    logic          e_byte_ready = 1'b0;
    logic          e_we         = 1'b0;
    logic [AW-1:0] e_addr       = '0;
    logic [31:0]   e_data       = '0;
    logic          e_cpu_reset  = 1'b1;
    logic          e_busy       = 1'b0;
    logic          e_done       = 1'b0;
    logic          e_error      = 1'b0;

    task automatic model_outputs();
        e_byte_ready = (m_phase == PH_LOAD) || (m_phase == PH_CHECK);
        e_busy       = e_byte_ready;
        e_done       = (m_phase == PH_DONE);
        e_error      = (m_phase == PH_ERR);
        e_cpu_reset  = (m_phase != PH_DONE);
    endtask

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_need    = 0;
        m_written = 0;
        m_bytes.delete();
        e_we      = 1'b0;
        e_addr    = '0;
        e_data    = '0;
        model_outputs();
    endtask

    task automatic model_step();
        logic       acc;
        logic [7:0] x;
        int         n;
        acc = byte_valid && e_byte_ready;
        if (e_we) begin
            e_we   = 1'b0;
            e_addr = AW'(m_written % DEPTH);
        end
        case (m_phase)
            PH_LOAD: if (acc) begin
                m_bytes.push_back(byte_in);
                n = m_bytes.size();
                if (n % 4 == 0) begin
                    e_we   = 1'b1;
                    e_addr = AW'(m_written);
                    e_data = {m_bytes[n-4], m_bytes[n-3], m_bytes[n-2], m_bytes[n-1]};
                    m_written++;
                    if (m_written == m_need) m_phase = PH_CHECK;
                end
            end
            PH_CHECK: if (acc) begin
                x = 8'h00;
                foreach (m_bytes[i]) x = x ^ m_bytes[i];
                m_phase = (byte_in == x) ? PH_DONE : PH_ERR;
            end
            default: if (start) begin
                m_bytes.delete();
                m_written = 0;
                e_addr    = '0;
                m_need    = int'(load_count);
                if (m_need > DEPTH)   m_phase = PH_ERR;
                else if (m_need == 0) m_phase = PH_CHECK;
                else                  m_phase = PH_LOAD;
            end
        endcase
        model_outputs();
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) model_reset();
        else       model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("byte_ready", byte_ready, e_byte_ready);
            chk("imem_we",    imem_we,    e_we);
            chk("imem_addr",  imem_addr,  e_addr);
            chk("cpu_reset",  cpu_reset,  e_cpu_reset);
            chk("busy",       busy,       e_busy);
            chk("done",       done,       e_done);
            chk("error",      error,      e_error);
            if (e_we) chk("imem_data", imem_data, e_data);
        end
    end

    // Write log for literal checks.
    logic [AW+31:0] wlog[$];
    initial forever begin
        @(negedge clock);
        if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_data});
    end

    task automatic chk_log(input int idx, input logic [AW-1:0] a, input logic [31:0] d);
        if (idx < wlog.size()) chk($sformatf("write%0d", idx), wlog[idx], {a, d});
        else chk($sformatf("write%0d_count", idx), wlog.size(), idx + 1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [7:0] img [8] = '{8'h8B, 8'h02, 8'h00, 8'h20, 8'hD1, 8'h00, 8'h04, 8'h21};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int cnt);
        start      = 1'b1;
        load_count = (AW+1)'(cnt);
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_words(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(img[i]);
            if (gaps) begin
                if (i == 3) start = 1'b1;
                load_count = 11'd5;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic chk_final(input string tag, input logic d, input logic e, input logic cr);
        chk({tag, "_done"},      done,      d);
        chk({tag, "_error"},     error,     e);
        chk({tag, "_cpu_reset"}, cpu_reset, cr);
        chk({tag, "_busy"},      busy,      1'b0);
    endtask

    initial begin
        tick();
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Idle after reset: stray bytes are ignored.
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_imem_we",    imem_we,    1'b0);
        chk("rst_imem_data",  imem_data,  32'h0);
        chk_final("rst", 1'b0, 1'b0, 1'b1);
        send_byte(8'hAA);
        tick();
        send_byte(8'h55);
        chk("idle_no_writes", wlog.size(), 0);

        // Two-word load with correct checksum.
        wlog.delete();
        do_start(2);
        send_words(8, 1'b0);
        send_byte(8'h5D);
        chk("load_a_count", wlog.size(), 2);
        chk_log(0, 10'd0, 32'h8B020020);
        chk_log(1, 10'd1, 32'hD1000421);
        chk_final("load_a", 1'b1, 1'b0, 1'b0);
        tick();

        // Bad checksum, then a clean retry.
        wlog.delete();
        do_start(2);
        send_words(8, 1'b0);
        send_byte(8'h5C);
        chk("bad_count", wlog.size(), 2);
        chk_final("bad", 1'b0, 1'b1, 1'b1);
        tick();
        wlog.delete();
        do_start(2);
        send_words(8, 1'b0);
        send_byte(8'h5D);
        chk_log(1, 10'd1, 32'hD1000421);
        chk_final("retry", 1'b1, 1'b0, 1'b0);

        // Gapped stream with a stray start mid-load and a delay before checksum.
        wlog.delete();
        do_start(2);
        send_words(8, 1'b1);
        tick();
        tick();
        chk("gap_busy_wait", busy, 1'b1);
        send_byte(8'h5D);
        chk_log(0, 10'd0, 32'h8B020020);
        chk_log(1, 10'd1, 32'hD1000421);
        chk_final("gap", 1'b1, 1'b0, 1'b0);

        // Empty image and oversize request.
        wlog.delete();
        do_start(0);
        chk("zero_ready", byte_ready, 1'b1);
        send_byte(8'h00);
        chk("zero_no_writes", wlog.size(), 0);
        chk_final("zero", 1'b1, 1'b0, 1'b0);
        do_start(1025);
        chk("over_error", error, 1'b1);
        chk("over_ready", byte_ready, 1'b0);
        tick();
        chk("over_ready_hold", byte_ready, 1'b0);
        chk("over_cpu_reset", cpu_reset, 1'b1);

        // Reset in the middle of a load, then a full reload.
        wlog.delete();
        do_start(2);
        send_words(5, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_byte_ready", byte_ready, 1'b0);
        chk("mid_rst_imem_we",    imem_we,    1'b0);
        chk("mid_rst_imem_addr",  imem_addr,  10'd0);
        chk_final("mid_rst", 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        wlog.delete();
        do_start(2);
        send_words(8, 1'b0);
        send_byte(8'h5D);
        chk_log(0, 10'd0, 32'h8B020020);
        chk_log(1, 10'd1, 32'hD1000421);
        chk_final("reload", 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
